tone_classifier: RTL and testbench



---
 rtl/tone_pkg.sv | 24 ++
 rtl/tone_sync.sv | 28 ++
 rtl/tone_classifier.sv | 187 ++++++++++++++++++
 tb/tb_tone_classifier.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// tone_pkg: shared types and constants for the tone classifier slice.
//   - tone_state_t : qualifier FSM states
//   - DEF_DWELL / DEF_GAP / DEF_TIMEOUT : default timing constants
//   - CH_* : channel-index map used by the drive control logic
package tone_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        LOCKED  = 2'd2
    } tone_state_t;

    localparam int DEF_DWELL   = 25_000_000;
    localparam int DEF_GAP     = 1_000;
    localparam int DEF_TIMEOUT = 250_000_000;

    // Drive map: channel 0 is the 1 kHz stop tone and has top priority.
    localparam int unsigned CH_STOP  = 0;
    localparam int unsigned CH_FWD   = 1;
    localparam int unsigned CH_LEFT  = 2;
    localparam int unsigned CH_RIGHT = 3;
    localparam int unsigned CH_REV   = 4;

endpackage

// File: rtl/tone_sync.sv
// tone_sync: W-wide two-flop synchroniser for the asynchronous comparator
// outputs. Output lags input by two clk edges.
//   clk  : system clock
//   rst  : asynchronous active-high reset (clears both stages)
//   din  : asynchronous inputs
//   dout : synchronised outputs
module tone_sync #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1 <= '0;
            dout   <= '0;
        end else begin
            stage1 <= din;
            dout   <= stage1;
        end
    end

endmodule

// File: rtl/tone_classifier.sv
// tone_classifier: N-channel tone/command qualifier.
// Synchronises the band-pass comparator outputs, merges push-button
// overrides, picks the lowest-index active channel and commits it once it
// has been present for DWELL cycles (short dropouts up to GAP cycles are
// tolerated). A committed channel is not re-triggered while it stays present.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   enable    : detection enable; low returns to IDLE and clears det_valid
//   tone_raw  : asynchronous comparator outputs (NUM_CH wide)
//   btn       : synchronous debounced push-buttons (NUM_CH wide)
//   det_idx   : last committed channel (retained across enable low)
//   det_valid : det_idx holds a channel committed since enable rose
//   det_pulse : one-cycle strobe on every commit
//   busy      : high while qualifying a candidate
// Optional build macro TONE_TIMEOUT_EN adds parameter TIMEOUT: det_valid
// drops after TIMEOUT quiet cycles counted since the last commit.
module tone_classifier
    import tone_pkg::*;
#(
    parameter int NUM_CH = 5,
    parameter int CNT_W  = 26,
    parameter int DWELL  = DEF_DWELL,
    parameter int GAP    = DEF_GAP,
    parameter int IDX_W  = $clog2(NUM_CH)
`ifdef TONE_TIMEOUT_EN
    ,
    parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] tone_raw,
    input  logic [NUM_CH-1:0] btn,
    output logic [IDX_W-1:0]  det_idx,
    output logic              det_valid,
    output logic              det_pulse,
    output logic              busy
);

    localparam int GAP_W = $clog2(GAP + 2);
    localparam logic [CNT_W-1:0] DWELL_C = CNT_W'(DWELL);
    localparam logic [GAP_W-1:0] GAP_C   = GAP_W'(GAP);

`ifdef TONE_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    logic [TMR_W-1:0] tmr;
`endif

    logic [NUM_CH-1:0] toneSync;
    logic [NUM_CH-1:0] present;
    logic              any;
    logic [IDX_W-1:0]  candidate;
    logic [IDX_W-1:0]  cand;
    logic [CNT_W-1:0]  cnt;
    logic [GAP_W-1:0]  gapCnt;
    tone_state_t       state;

    tone_sync #(
        .W (NUM_CH)
    ) uSync (
        .clk  (clk),
        .rst  (rst),
        .din  (tone_raw),
        .dout (toneSync)
    );

    assign present = btn | toneSync;
    assign any     = |present;
    assign busy    = (state == QUALIFY);

    // Priority encoder: scan from the top so the lowest set index wins.
    always_comb begin
        candidate = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (present[i-1]) begin
                candidate = IDX_W'(i - 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            gapCnt    <= '0;
            det_idx   <= '0;
            det_valid <= 1'b0;
            det_pulse <= 1'b0;
`ifdef TONE_TIMEOUT_EN
            tmr       <= '0;
`endif
        end else if (!enable) begin
            state     <= IDLE;
            cnt       <= '0;
            gapCnt    <= '0;
            det_valid <= 1'b0;
            det_pulse <= 1'b0;
`ifdef TONE_TIMEOUT_EN
            tmr       <= '0;
`endif
        end else begin
            det_pulse <= 1'b0;

`ifdef TONE_TIMEOUT_EN
            // Quiet-cycle timer; a commit below overrides these updates.
            if (det_valid && !any) begin
                if (tmr >= TMR_LAST) begin
                    det_valid <= 1'b0;
                end else begin
                    tmr <= tmr + 1'b1;
                end
            end
`endif

            case (state)
                IDLE: begin
                    if (any) begin
                        state  <= QUALIFY;
                        cand   <= candidate;
                        cnt    <= CNT_W'(1);
                        gapCnt <= '0;
                    end
                end

                QUALIFY: begin
                    if (cnt >= DWELL_C) begin
                        // Dwell satisfied on the previous edge: commit now.
                        state     <= LOCKED;
                        det_idx   <= cand;
                        det_valid <= 1'b1;
                        det_pulse <= 1'b1;
                        cnt       <= '0;
                        gapCnt    <= '0;
`ifdef TONE_TIMEOUT_EN
                        tmr       <= '0;
`endif
                    end else if (!any) begin
                        // Dropout: hold cnt, give up once GAP is exceeded.
                        if (gapCnt >= GAP_C) begin
                            state  <= IDLE;
                            cnt    <= '0;
                            gapCnt <= '0;
                        end else begin
                            gapCnt <= gapCnt + 1'b1;
                        end
                    end else if (candidate == cand) begin
                        cnt    <= (cnt == '1) ? cnt : cnt + 1'b1;
                        gapCnt <= '0;
                    end else begin
                        cand   <= candidate;
                        cnt    <= CNT_W'(1);
                        gapCnt <= '0;
                    end
                end

                LOCKED: begin
                    if (!any) begin
                        if (gapCnt >= GAP_C) begin
                            state  <= IDLE;
                            gapCnt <= '0;
                        end else begin
                            gapCnt <= gapCnt + 1'b1;
                        end
                    end else if (candidate != cand) begin
                        state  <= QUALIFY;
                        cand   <= candidate;
                        cnt    <= CNT_W'(1);
                        gapCnt <= '0;
                    end else begin
                        // Committed channel still present: no re-trigger.
                        gapCnt <= '0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    gapCnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_classifier.sv
// tb_tone_classifier: directed bench for tone_classifier with NUM_CH=5,
// DWELL=10, GAP=2. Edge numbers are counted from the first posedge after
// each per-test reset; with tone_raw driven before that edge a clean commit
// lands on edge 13 (two synchroniser edges, one entry edge, ten dwell).
module tb_tone_classifier;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [4:0] tone_raw;
    logic [4:0] btn;
    logic [2:0] det_idx;
    logic       det_valid;
    logic       det_pulse;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    int edgeNum     = 0;
    int base        = 0;
    int pulseCnt    = 0;
    int lastPulse   = 0;

    always #5 clk = ~clk;

    tone_classifier #(
        .NUM_CH (5),
        .CNT_W  (8),
        .DWELL  (10),
        .GAP    (2)
`ifdef TONE_TIMEOUT_EN
        ,
        .TIMEOUT (20)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .tone_raw  (tone_raw),
        .btn       (btn),
        .det_idx   (det_idx),
        .det_valid (det_valid),
        .det_pulse (det_pulse),
        .busy      (busy)
    );

    always @(posedge clk) edgeNum <= edgeNum + 1;

    always @(negedge clk) begin
        if (det_pulse) begin
            pulseCnt  = pulseCnt + 1;
            lastPulse = edgeNum - base;
        end
    end

    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic doReset();
        tone_raw = '0;
        btn      = '0;
        enable   = 1'b1;
        rst      = 1'b1;
        waitEdges(1);
        rst      = 1'b0;
        base     = edgeNum;
        pulseCnt = 0;
        lastPulse = 0;
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        tone_raw = '0;
        btn      = '0;
        waitEdges(2);
        check("rst_idx",   int'(det_idx),   0);
        check("rst_valid", int'(det_valid), 0);
        check("rst_pulse", int'(det_pulse), 0);
        check("rst_busy",  int'(busy),      0);

        // Clean tone on channel 2, held.
        doReset();
        tone_raw = 5'b00100;
        waitEdges(2);
        check("t1_busy_e2", int'(busy), 0);
        waitEdges(1);
        check("t1_busy_e3", int'(busy), 1);
        waitEdges(9);
        check("t1_nopulse_e12", int'(det_pulse), 0);
        waitEdges(1);
        check("t1_pulse_e13", int'(det_pulse), 1);
        check("t1_idx",       int'(det_idx),   2);
        check("t1_valid",     int'(det_valid), 1);
        check("t1_busy_lock", int'(busy),      0);
        waitEdges(1);
        check("t1_pulse_e14", int'(det_pulse), 0);
        waitEdges(100);
        check("t1_no_retrig", pulseCnt, 1);

        // Channel 3 with a 2-cycle dropout: tolerated.
        doReset();
        tone_raw = 5'b01000;
        waitEdges(6);
        tone_raw = '0;
        waitEdges(2);
        tone_raw = 5'b01000;
        waitEdges(4);
        tone_raw = '0;
        waitEdges(10);
        check("t2a_pulses",    pulseCnt,       1);
        check("t2a_pulse_edge", lastPulse,     15);
        check("t2a_idx",       int'(det_idx),  3);

        // Same with a 3-cycle dropout: candidate lost, no commit.
        doReset();
        tone_raw = 5'b01000;
        waitEdges(6);
        tone_raw = '0;
        waitEdges(3);
        tone_raw = 5'b01000;
        waitEdges(4);
        tone_raw = '0;
        waitEdges(10);
        check("t2b_pulses", pulseCnt,        0);
        check("t2b_valid",  int'(det_valid), 0);

        // Channel 4 then channel 1 joins: restart on the higher priority.
        doReset();
        tone_raw = 5'b10000;
        waitEdges(5);
        tone_raw = 5'b10010;
        waitEdges(20);
        check("t3_pulses",     pulseCnt,      1);
        check("t3_pulse_edge", lastPulse,     18);
        check("t3_idx",        int'(det_idx), 1);

        // enable low clears det_valid but keeps det_idx.
        tone_raw = '0;
        enable   = 1'b0;
        waitEdges(1);
        check("en_valid_clr", int'(det_valid), 0);
        check("en_idx_kept",  int'(det_idx),   1);
        enable = 1'b1;

        // Button 0 beats tone 4; buttons bypass the synchroniser.
        doReset();
        btn      = 5'b00001;
        tone_raw = 5'b10000;
        waitEdges(10);
        check("t4_nopulse_e10", pulseCnt, 0);
        waitEdges(1);
        check("t4_pulse_e11", int'(det_pulse), 1);
        check("t4_idx",       int'(det_idx),   0);
        waitEdges(30);
        check("t4_pulses",    pulseCnt,        1);
        check("t4_idx_final", int'(det_idx),   0);

        // enable dropped at cnt=7 then restored: full dwell needed again.
        doReset();
        tone_raw = 5'b00100;
        waitEdges(9);
        check("t5_busy_cnt7", int'(busy), 1);
        enable = 1'b0;
        waitEdges(3);
        check("t5_busy_dis",  int'(busy),      0);
        check("t5_valid_dis", int'(det_valid), 0);
        enable = 1'b1;
        waitEdges(10);
        check("t5_nopulse_e22", pulseCnt, 0);
        waitEdges(1);
        check("t5_pulse_edge", lastPulse, 23);
        check("t5_idx",        int'(det_idx), 2);

        // Async reset mid-qualify: outputs clear without a clock edge.
        doReset();
        tone_raw = 5'b00100;
        waitEdges(8);
        check("t6_busy_pre", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_busy",  int'(busy),      0);
        check("t6_valid", int'(det_valid), 0);
        check("t6_pulse", int'(det_pulse), 0);
        check("t6_idx",   int'(det_idx),   0);
        tone_raw = '0;
        waitEdges(1);
        rst = 1'b0;
        waitEdges(20);
        check("t6_no_pulse", pulseCnt, 0);

`ifdef TONE_TIMEOUT_EN
        // Commit, go quiet: det_valid drops on the 20th quiet cycle.
        doReset();
        tone_raw = 5'b01000;
        waitEdges(13);
        check("to_pulse", int'(det_pulse), 1);
        tone_raw = '0;
        waitEdges(21);
        check("to_valid_e34", int'(det_valid), 1);
        waitEdges(1);
        check("to_valid_e35", int'(det_valid), 0);
        check("to_idx",       int'(det_idx),   3);
        check("to_pulses",    pulseCnt,        1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
